game_state_controller: RTL and testbench

- Top-level game sequencer that produces the 2-bit game state consumed by the countdown timer, display and sprite logic.
- Takes the player start button, a collision level from the collision detector, and the four BCD digits returned by the countdown timer.
- Decides transitions between IDLE, OPENING_SCREEN, GAME_RUNNING and GAME_OVER.
- Tracks lives, a post-hit invulnerability window and win/loss.

---
 rtl/game_state_controller.sv | 187 ++++++++++++++++++
 tb/tb_game_state_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// Game sequencer: debounces the start button, walks IDLE -> OPENING_SCREEN -> GAME_RUNNING -> GAME_OVER,
// and tracks lives, the post-hit invulnerability window and the win/loss outcome.
module game_state_controller #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int SPLASH_CYCLES    = 200000000,
  parameter int INVULN_CYCLES    = 100000000,
  parameter int OVER_HOLD_CYCLES = 100000000,
  parameter int START_LIVES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       collision,
  input  logic [3:0] num0_w,
  input  logic [3:0] num1_w,
  input  logic [3:0] num2_w,
  input  logic [3:0] num3_w,
  output logic [1:0] game_state_w,
  output logic [1:0] lives,
  output logic       win,
  output logic       hit_pulse,
  output logic       invuln
);

  localparam int DW = (DEBOUNCE_CYCLES  > 1) ? $clog2(DEBOUNCE_CYCLES)  : 1;
  localparam int SW = (SPLASH_CYCLES    > 1) ? $clog2(SPLASH_CYCLES)    : 1;
  localparam int IW = (INVULN_CYCLES    > 1) ? $clog2(INVULN_CYCLES)    : 1;
  localparam int HW = (OVER_HOLD_CYCLES > 1) ? $clog2(OVER_HOLD_CYCLES) : 1;

  localparam logic [1:0]    START_L  = 2'(START_LIVES);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SP_LAST  = SW'(SPLASH_CYCLES - 1);
  localparam logic [IW-1:0] IV_LAST  = IW'(INVULN_CYCLES - 1);
  localparam logic [HW-1:0] HD_LAST  = HW'(OVER_HOLD_CYCLES - 1);

  // Encoding is decoded directly by the countdown timer; do not reorder.
  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    OPENING_SCREEN = 2'b01,
    GAME_RUNNING   = 2'b10,
    GAME_OVER      = 2'b11
  } state_t;

  state_t        state;
  logic          btn_meta;
  logic          btn_sync;
  logic          db_level;
  logic          db_prev;
  logic [DW-1:0] db_cnt;
  logic          coll_prev;
  logic [SW-1:0] splash_cnt;
  logic [IW-1:0] inv_cnt;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          armed;

  logic press;
  logic hit_evt;
  logic tz;
  logic accepted;
  logic fatal;

  assign press    = db_level & ~db_prev;
  assign hit_evt  = collision & ~coll_prev;
  assign tz       = (num0_w == 4'd0) && (num1_w == 4'd0) && (num2_w == 4'd0) && (num3_w == 4'd0);
  assign accepted = hit_evt && !invuln;
  assign fatal    = accepted && (lives == 2'd1);

  assign game_state_w = state;

  // Start button: two-flop synchroniser, then a stability counter that must
  // see the new value for DEBOUNCE_CYCLES consecutive cycles before it is taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      db_level  <= 1'b0;
      db_prev   <= 1'b0;
      db_cnt    <= '0;
      coll_prev <= 1'b0;
    end else begin
      btn_meta  <= start_btn;
      btn_sync  <= btn_meta;
      db_prev   <= db_level;
      coll_prev <= collision;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lives      <= START_L;
      win        <= 1'b0;
      hit_pulse  <= 1'b0;
      invuln     <= 1'b0;
      splash_cnt <= '0;
      inv_cnt    <= '0;
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      armed      <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state      <= OPENING_SCREEN;
            splash_cnt <= '0;
            lives      <= START_L;
            win        <= 1'b0;
          end
        end

        OPENING_SCREEN: begin
          if (splash_cnt == SP_LAST) begin
            state   <= GAME_RUNNING;
            armed   <= 1'b0;
            invuln  <= 1'b0;
            inv_cnt <= '0;
          end else begin
            splash_cnt <= splash_cnt + SW'(1);
          end
        end

        GAME_RUNNING: begin
          // Zero digits seen before the countdown reloads must not end the game.
          if (!armed && !tz) begin
            armed <= 1'b1;
          end
          if (invuln) begin
            if (inv_cnt == IV_LAST) begin
              invuln <= 1'b0;
            end else begin
              inv_cnt <= inv_cnt + IW'(1);
            end
          end
          if (accepted) begin
            hit_pulse <= 1'b1;
            if (lives != 2'd0) begin
              lives <= lives - 2'd1;
            end
          end
          // A fatal hit beats a same-cycle timer expiry.
          if (fatal) begin
            state     <= GAME_OVER;
            win       <= 1'b0;
            invuln    <= 1'b0;
            hold_cnt  <= '0;
            hold_done <= 1'b0;
          end else if (tz && armed) begin
            state     <= GAME_OVER;
            win       <= 1'b1;
            invuln    <= 1'b0;
            hold_cnt  <= '0;
            hold_done <= 1'b0;
          end else if (accepted) begin
            invuln  <= 1'b1;
            inv_cnt <= '0;
          end
        end

        GAME_OVER: begin
          invuln <= 1'b0;
          if (!hold_done) begin
            if (hold_cnt == HD_LAST) begin
              hold_done <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end else if (press) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with small timing parameters:
// a vector table for the running game plus hand-written start/over/reset sequences.
module tb_game_state_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       collision;
  logic [3:0] num0_w, num1_w, num2_w, num3_w;
  logic [1:0] game_state_w;
  logic [1:0] lives;
  logic       win;
  logic       hit_pulse;
  logic       invuln;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        btn;
    logic        col;
    logic [15:0] dig;
    logic [1:0]  st;
    logic [1:0]  lv;
    logic        w;
    logic        h;
    logic        iv;
  } vec_t;

  vec_t vecs[22];

  game_state_controller #(
    .DEBOUNCE_CYCLES(4),
    .SPLASH_CYCLES(10),
    .INVULN_CYCLES(8),
    .OVER_HOLD_CYCLES(6),
    .START_LIVES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_btn(start_btn),
    .collision(collision),
    .num0_w(num0_w),
    .num1_w(num1_w),
    .num2_w(num2_w),
    .num3_w(num3_w),
    .game_state_w(game_state_w),
    .lives(lives),
    .win(win),
    .hit_pulse(hit_pulse),
    .invuln(invuln)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_dig(input logic [15:0] d);
    num3_w = d[15:12];
    num2_w = d[11:8];
    num1_w = d[7:4];
    num0_w = d[3:0];
  endtask

  function automatic vec_t mk(input logic btn, input logic col, input logic [15:0] dig,
                              input logic [1:0] st, input logic [1:0] lv, input logic w,
                              input logic h, input logic iv);
    vec_t v;
    v.btn = btn; v.col = col; v.dig = dig;
    v.st = st; v.lv = lv; v.w = w; v.h = h; v.iv = iv;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    start_btn = v.btn;
    collision = v.col;
    set_dig(v.dig);
    tick();
    chk({tag, "_state"},  32'(game_state_w), 32'(v.st));
    chk({tag, "_lives"},  32'(lives),        32'(v.lv));
    chk({tag, "_win"},    32'(win),          32'(v.w));
    chk({tag, "_hit"},    32'(hit_pulse),    32'(v.h));
    chk({tag, "_invuln"}, 32'(invuln),       32'(v.iv));
  endtask

  // Clean press from IDLE, then ride through the splash screen; a collision
  // edge during the splash must not cost a life.
  task automatic start_game(input string tag);
    int n;
    start_btn = 1'b0;
    collision = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    start_btn = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (game_state_w != 2'b01 && n < 20);
    chk({tag, "_press_latency"}, 32'(n), 32'd7);
    chk({tag, "_open_lives"}, 32'(lives), 32'd3);
    chk({tag, "_open_win"},   32'(win),   32'd0);
    n = 0;
    do begin
      collision = (n == 2);
      tick();
      n++;
    end while (game_state_w != 2'b10 && n < 20);
    collision = 1'b0;
    chk({tag, "_splash_len"}, 32'(n), 32'd10);
    chk({tag, "_run_lives"},  32'(lives), 32'd3);
  endtask

  // Release the button, press again, and expect GAME_OVER -> IDLE.
  task automatic return_idle(input string tag);
    int n;
    start_btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    start_btn = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (game_state_w != 2'b00 && n < 20);
    chk({tag, "_idle_latency"}, 32'(n), 32'd7);
  endtask

  initial begin
    // Game 1: hit path, ignored hit during invuln, simultaneous fatal hit + armed tz.
    // Rows 17..21 raise the button so the debounced press lands 2 cycles into GAME_OVER.
    vecs[0]  = mk(0, 0, 16'h0000, 2'b10, 2'd3, 0, 0, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 2'b10, 2'd3, 0, 0, 0);
    vecs[2]  = mk(0, 0, 16'h0025, 2'b10, 2'd3, 0, 0, 0);
    vecs[3]  = mk(0, 1, 16'h0025, 2'b10, 2'd2, 0, 1, 1);
    vecs[4]  = mk(0, 0, 16'h0024, 2'b10, 2'd2, 0, 0, 1);
    vecs[5]  = mk(0, 0, 16'h0023, 2'b10, 2'd2, 0, 0, 1);
    vecs[6]  = mk(0, 1, 16'h0022, 2'b10, 2'd2, 0, 0, 1);
    vecs[7]  = mk(0, 0, 16'h0021, 2'b10, 2'd2, 0, 0, 1);
    vecs[8]  = mk(0, 0, 16'h0020, 2'b10, 2'd2, 0, 0, 1);
    vecs[9]  = mk(0, 0, 16'h0019, 2'b10, 2'd2, 0, 0, 1);
    vecs[10] = mk(0, 0, 16'h0018, 2'b10, 2'd2, 0, 0, 1);
    vecs[11] = mk(0, 0, 16'h0017, 2'b10, 2'd2, 0, 0, 0);
    vecs[12] = mk(0, 1, 16'h0016, 2'b10, 2'd1, 0, 1, 1);
    vecs[13] = mk(0, 0, 16'h0015, 2'b10, 2'd1, 0, 0, 1);
    vecs[14] = mk(0, 0, 16'h0014, 2'b10, 2'd1, 0, 0, 1);
    vecs[15] = mk(0, 0, 16'h0013, 2'b10, 2'd1, 0, 0, 1);
    vecs[16] = mk(0, 0, 16'h0012, 2'b10, 2'd1, 0, 0, 1);
    vecs[17] = mk(1, 0, 16'h0011, 2'b10, 2'd1, 0, 0, 1);
    vecs[18] = mk(1, 0, 16'h0010, 2'b10, 2'd1, 0, 0, 1);
    vecs[19] = mk(1, 0, 16'h0009, 2'b10, 2'd1, 0, 0, 1);
    vecs[20] = mk(1, 0, 16'h0008, 2'b10, 2'd1, 0, 0, 0);
    vecs[21] = mk(1, 1, 16'h0000, 2'b11, 2'd0, 0, 1, 0);

    rst = 1'b0;
    start_btn = 1'b0;
    collision = 1'b0;
    set_dig(16'h0000);
    tick();
    tick();
    chk("reset_state",  32'(game_state_w), 32'd0);
    chk("reset_lives",  32'(lives),        32'd3);
    chk("reset_win",    32'(win),          32'd0);
    chk("reset_hit",    32'(hit_pulse),    32'd0);
    chk("reset_invuln", 32'(invuln),       32'd0);
    rst = 1'b1;

    start_btn = 1'b1;
    tick();
    tick();
    start_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("glitch_state%0d", i), 32'(game_state_w), 32'd0);
    end

    set_dig(16'h0000);
    start_game("g1");
    for (int i = 0; i < 22; i++) apply(vecs[i], $sformatf("row%0d", i));

    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("hold_state%0d", i), 32'(game_state_w), 32'd3);
    end
    return_idle("g1");
    chk("g1_idle_lives", 32'(lives), 32'd0);
    chk("g1_idle_win",   32'(win),   32'd0);

    // Game 2: countdown reaches zero on the same cycle as a non-fatal hit.
    set_dig(16'h0000);
    start_game("g2");
    apply(mk(1, 0, 16'h0000, 2'b10, 2'd3, 0, 0, 0), "g2_stale");
    apply(mk(1, 0, 16'h0025, 2'b10, 2'd3, 0, 0, 0), "g2_d25");
    apply(mk(1, 0, 16'h0010, 2'b10, 2'd3, 0, 0, 0), "g2_d10");
    apply(mk(1, 0, 16'h0001, 2'b10, 2'd3, 0, 0, 0), "g2_d01");
    apply(mk(1, 1, 16'h0000, 2'b11, 2'd2, 1, 1, 0), "g2_win_hit");
    apply(mk(1, 0, 16'h0000, 2'b11, 2'd2, 1, 0, 0), "g2_after");
    return_idle("g2");
    chk("g2_idle_lives", 32'(lives), 32'd2);
    chk("g2_idle_win",   32'(win),   32'd1);

    // Game 3: reset while invulnerable with one life left.
    start_game("g3");
    apply(mk(1, 1, 16'h0050, 2'b10, 2'd2, 0, 1, 1), "g3_hit1");
    for (int k = 1; k <= 8; k++)
      apply(mk(1, 0, 16'h0050, 2'b10, 2'd2, 0, 0, logic'(k < 8)), $sformatf("g3_win%0d", k));
    apply(mk(1, 1, 16'h0050, 2'b10, 2'd1, 0, 1, 1), "g3_hit2");
    apply(mk(1, 0, 16'h0050, 2'b10, 2'd1, 0, 0, 1), "g3_pre_rst");
    rst = 1'b0;
    tick();
    chk("midrst_state",  32'(game_state_w), 32'd0);
    chk("midrst_lives",  32'(lives),        32'd3);
    chk("midrst_win",    32'(win),          32'd0);
    chk("midrst_hit",    32'(hit_pulse),    32'd0);
    chk("midrst_invuln", 32'(invuln),       32'd0);
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
